// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg: shared constants, clear-FSM state type and lane-merge helper for ram_dp_banked
package ram_dp_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int MAX_W = 1024;
    localparam int MAX_L = 128;

    typedef enum logic {CLEAR, READY} clr_state_t;

    // Replace the lanes of old_w selected by mask with the matching lanes of new_w
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_L-1:0] mask,
        input int               lw
    );
        logic [MAX_W-1:0] r;
        int l;
        int k;
        l = 0;
        k = 0;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = mask[l[6:0]] ? new_w[i] : old_w[i];
            k++;
            if (k == lw) begin
                k = 0;
                l++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_dp_clear_ctrl.sv
// ram_dp_clear_ctrl: post-reset clear sweep, one word per cycle, then hands the RAM to the ports
module ram_dp_clear_ctrl
    import ram_dp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr
);

    clr_state_t state;

    // Sweep addresses 0..max once, holding at the last address instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            busy  <= CLEAR_ON_RESET != 0;
            addr  <= '0;
        end else if (state == CLEAR) begin
            addr  <= (&addr) ? addr : addr + ADDR_WIDTH'(1);
            state <= (&addr) ? READY : CLEAR;
            busy  <= !(&addr);
        end
    end

endmodule

// File: rtl/ram_dp_banked.sv
// ram_dp_banked: true dual-port lane-writable RAM with clear sweep; define RAM_DP_OUTREG_EN for an extra output stage
module ram_dp_banked
    import ram_dp_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    LANE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 14,
    parameter int                    RDW_MODE       = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [LANE_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_busy,
    input  logic                             a_en,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH-1:0]            a_din,
    output logic [DATA_WIDTH-1:0]            a_dout,
    output logic                             a_valid,
    input  logic                             b_en,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] b_we,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic [DATA_WIDTH-1:0]            b_din,
    output logic [DATA_WIDTH-1:0]            b_dout,
    output logic                             b_valid,
    output logic                             collision
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] FILL = {LANES{CLEAR_VALUE}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  busy;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_dp_clear_ctrl #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clr (
        .clk (clk),
        .rst (rst),
        .busy(busy),
        .addr(clr_addr)
    );

    assign init_busy = busy;

    logic                  a_acc, b_acc, wa, wb;
    logic [LANES-1:0]      wa_we;
    logic [ADDR_WIDTH-1:0] wa_addr;
    logic [DATA_WIDTH-1:0] wa_din, a_old, b_old, a_mrg, b_mrg, a_rd, b_rd;

    assign a_acc   = !rst && !busy && a_en;
    assign b_acc   = !rst && !busy && b_en;
    assign wa      = busy || (a_acc && |a_we);
    assign wb      = b_acc && |b_we;
    assign wa_we   = busy ? '1 : a_we;
    assign wa_addr = busy ? clr_addr : a_addr;
    assign wa_din  = busy ? FILL : a_din;
    assign a_old   = mem[a_addr];
    assign b_old   = mem[b_addr];
    assign a_mrg   = DATA_WIDTH'(lane_merge(MAX_W'(a_old), MAX_W'(a_din), MAX_L'(a_we), LANE_WIDTH));
    assign b_mrg   = DATA_WIDTH'(lane_merge(MAX_W'(b_old), MAX_W'(b_din), MAX_L'(b_we), LANE_WIDTH));
    assign a_rd    = (RDW_MODE == RDW_READ_FIRST) ? a_old : a_mrg;
    assign b_rd    = (RDW_MODE == RDW_READ_FIRST) ? b_old : b_mrg;

    // Lane writes; A is applied last so it wins lanes both ports write at one address
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wb && b_we[l]) mem[b_addr][l*LANE_WIDTH +: LANE_WIDTH] <= b_din[l*LANE_WIDTH +: LANE_WIDTH];
            if (wa && wa_we[l]) mem[wa_addr][l*LANE_WIDTH +: LANE_WIDTH] <= wa_din[l*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  a_vq, b_vq;

    // First read stage: dout holds when idle, valid pulses per accepted access
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            a_vq      <= 1'b0;
            b_vq      <= 1'b0;
            collision <= 1'b0;
        end else begin
            a_q       <= a_acc ? a_rd : a_q;
            b_q       <= b_acc ? b_rd : b_q;
            a_vq      <= a_acc;
            b_vq      <= b_acc;
            collision <= a_acc && b_acc && (a_addr == b_addr) && |(a_we & b_we);
        end
    end

`ifdef RAM_DP_OUTREG_EN
    // Extra output stage for timing; collision is not delayed
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout  <= '0;
            b_dout  <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            a_dout  <= a_q;
            b_dout  <= b_q;
            a_valid <= a_vq;
            b_valid <= b_vq;
        end
    end
`else
    assign a_dout  = a_q;
    assign b_dout  = b_q;
    assign a_valid = a_vq;
    assign b_valid = b_vq;
`endif

endmodule

// File: tb/tb_ram_dp_banked.sv
// tb_ram_dp_banked: write-first and read-first instances driven together and checked against a word-level model
module tb_ram_dp_banked;

`ifdef RAM_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [3:0]  a_we = '0, b_we = '0, a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;
    logic        busy0, busy1, av0, av1, bv0, bv1, col0, col1;
    logic [31:0] ad0, ad1, bd0, bd1;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    ram_dp_banked #(.ADDR_WIDTH(4), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .init_busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(ad0), .a_valid(av0),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(bd0), .b_valid(bv0),
        .collision(col0)
    );

    ram_dp_banked #(.ADDR_WIDTH(4), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .init_busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(ad1), .a_valid(av1),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(bd1), .b_valid(bv1),
        .collision(col1)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int l = 0; l < 4; l++) if (w[l]) r[l*8 +: 8] = n[l*8 +: 8];
        return r;
    endfunction

    logic [31:0] m [16];
    int          left = 0;
    logic [31:0] s_a0 = 0, s_a1 = 0, s_b0 = 0, s_b1 = 0, t_a0 = 0, t_a1 = 0, t_b0 = 0, t_b1 = 0;
    logic        s_va = 0, s_vb = 0, t_va = 0, t_vb = 0, s_c = 0;

    initial for (int i = 0; i < 16; i++) m[i] = '0;

    always @(posedge clk) begin
        if (rst) begin
            left = 16;
            {s_a0, s_a1, s_b0, s_b1, t_a0, t_a1, t_b0, t_b1} = '0;
            {s_va, s_vb, t_va, t_vb, s_c} = '0;
        end else begin
            {t_a0, t_a1, t_b0, t_b1, t_va, t_vb} = {s_a0, s_a1, s_b0, s_b1, s_va, s_vb};
            s_va = 1'b0;
            s_vb = 1'b0;
            s_c  = 1'b0;
            if (left > 0) begin
                m[16-left] = '0;
                left--;
            end else begin
                logic [31:0] oa, ob;
                oa = m[a_addr];
                ob = m[b_addr];
                if (a_en) begin
                    s_a0 = mrg(oa, a_din, a_we);
                    s_a1 = oa;
                    s_va = 1'b1;
                end
                if (b_en) begin
                    s_b0 = mrg(ob, b_din, b_we);
                    s_b1 = ob;
                    s_vb = 1'b1;
                end
                s_c = a_en && b_en && a_addr == b_addr && (a_we & b_we) != 0;
                if (b_en) m[b_addr] = mrg(m[b_addr], b_din, b_we);
                if (a_en) m[a_addr] = mrg(m[a_addr], a_din, a_we);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy0", 32'(busy0), 32'(left > 0));
            chk("busy1", 32'(busy1), 32'(left > 0));
            chk("col0", 32'(col0), 32'(s_c));
            chk("col1", 32'(col1), 32'(s_c));
            chk("av0", 32'(av0), 32'(LAT == 2 ? t_va : s_va));
            chk("av1", 32'(av1), 32'(LAT == 2 ? t_va : s_va));
            chk("bv0", 32'(bv0), 32'(LAT == 2 ? t_vb : s_vb));
            chk("bv1", 32'(bv1), 32'(LAT == 2 ? t_vb : s_vb));
            chk("ad0", ad0, LAT == 2 ? t_a0 : s_a0);
            chk("ad1", ad1, LAT == 2 ? t_a1 : s_a1);
            chk("bd0", bd0, LAT == 2 ? t_b0 : s_b0);
            chk("bd1", bd1, LAT == 2 ? t_b1 : s_b1);
        end
    end

    task automatic cyc(input logic ae, input logic [3:0] aw, input logic [3:0] aa, input logic [31:0] ad,
                       input logic be, input logic [3:0] bw, input logic [3:0] ba, input logic [31:0] bd);
        a_en = ae; a_we = aw; a_addr = aa; a_din = ad;
        b_en = be; b_we = bw; b_addr = ba; b_din = bd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_dout", ad0, 32'h0);
        chk("rst_busy", 32'(busy0), 32'h1);
        rst = 1'b0;
        count_busy(n);
        chk("busy_cycles", n, 16);

        for (int i = 0; i < 16; i++) cyc(1, 0, 4'(i), 0, 1, 0, 4'(15 - i), 0);
        idle(LAT);
        chk("clr_read", ad0, 32'h0);

        for (int i = 0; i < 16; i++) cyc(1, 4'hF, 4'(i), 32'h01010101 * (i + 1), 0, 0, 0, 0);

        cyc(1, 4'hF, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        cyc(1, 4'b0010, 5, 32'h0000AA00, 0, 0, 0, 0);
        idle(LAT - 1);
        chk("wf_merge", ad0, 32'hDEADAAEF);
        chk("rf_merge", ad1, 32'hDEADBEEF);
        cyc(1, 0, 5, 0, 0, 0, 0, 0);
        idle(LAT - 1);
        chk("lane_read", ad0, 32'hDEADAAEF);

        cyc(1, 4'hF, 3, 32'h11111111, 0, 0, 0, 0);
        cyc(1, 4'hF, 3, 32'h22222222, 0, 0, 0, 0);
        idle(LAT - 1);
        chk("rdw_wf", ad0, 32'h22222222);
        chk("rdw_rf", ad1, 32'h11111111);

        cyc(1, 4'hF, 7, 32'h0, 0, 0, 0, 0);
        cyc(1, 4'b0011, 7, 32'hAAAAAAAA, 1, 4'b0110, 7, 32'hBBBBBBBB);
        chk("coll_hi", 32'(col0), 32'h1);
        idle(1);
        chk("coll_lo", 32'(col0), 32'h0);
        cyc(1, 0, 7, 0, 0, 0, 0, 0);
        idle(LAT - 1);
        chk("coll_word", ad0, 32'h00BBAAAA);
        cyc(1, 4'b0011, 8, 32'h12121212, 1, 4'b1100, 8, 32'h34343434);
        chk("no_coll", 32'(col0), 32'h0);

        cyc(1, 4'hF, 9, 32'h12345678, 0, 0, 0, 0);
        cyc(1, 4'hF, 9, 32'hAAAA5555, 1, 0, 9, 0);
        idle(LAT - 1);
        chk("xport_old", bd0, 32'h12345678);
        cyc(0, 0, 0, 0, 1, 0, 9, 0);
        idle(LAT - 1);
        chk("xport_new", bd0, 32'hAAAA5555);

        cyc(1, 4'hF, 1, 32'hCAFEF00D, 1, 4'hF, 2, 32'h0BADBEEF);
        cyc(1, 0, 2, 0, 1, 0, 1, 0);
        idle(LAT - 1);
        chk("indep_a", ad0, 32'h0BADBEEF);
        chk("indep_b", bd0, 32'hCAFEF00D);

        for (int i = 0; i < 40; i++)
            cyc(1'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom), 4'($urandom), $urandom);
        idle(2);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        chk("busy_restart", n, 16);
        for (int i = 0; i < 16; i++) cyc(1, 0, 4'(i), 0, 1, 0, 4'(i), 0);
        cyc(1, 0, 5, 0, 0, 0, 0, 0);
        idle(LAT);
        chk("reclear", ad0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
